// File: rtl/raggedstone_spinn_aer_if_button_pkg.sv
// ---------------------------------------------------------------------------
// raggedstone_spinn_aer_if_button_pkg
// Shared constants for the Raggedstone SpiNNaker AER push-button conditioner:
// default and simulation debounce / long-press constants, legal synchroniser
// depth limits, active-level encodings and a constant width-fit helper.
// No ports (package).
// ---------------------------------------------------------------------------
package raggedstone_spinn_aer_if_button_pkg;

    // Legal synchroniser chain lengths.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 8;

    // Input level meaning "pressed".
    localparam logic ACTIVE_LOW  = 1'b0;
    localparam logic ACTIVE_HIGH = 1'b1;

    // Hardware defaults (about 10 ms / 170 ms at 100 MHz).
    localparam int unsigned DEF_DBNC_CONST = 32'h000F_FFFF;
    localparam int unsigned DEF_LONG_CONST = 32'h00FF_FFFF;

    // Short values so simulations finish in a few hundred cycles.
    localparam int unsigned SIM_DBNC_CONST = 32'd4;
    localparam int unsigned SIM_LONG_CONST = 32'd10;

    // True when value is representable in width bits.
    function automatic logic value_fits(input longint unsigned value, input int width);
        return (value >> width) == 64'd0;
    endfunction

endpackage

// File: rtl/raggedstone_spinn_aer_if_button_ch.sv
// ---------------------------------------------------------------------------
// raggedstone_spinn_aer_if_button_ch
// One button channel: synchroniser chain, debounce counter, debounced level,
// press/release pulses and long-press hold counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pb_input      raw button level, asynchronous to clk
//   pb_debounced  debounced level in raw polarity
//   pb_pressed    debounced level, 1 = pressed
//   press_p       one-cycle pulse entering the active level
//   release_p     one-cycle pulse leaving the active level
//   long_p        one-cycle pulse once a press has been held LONG_CONST cycles
//   long_held     high from long_p until the matching release
// ---------------------------------------------------------------------------
module raggedstone_spinn_aer_if_button_ch
    import raggedstone_spinn_aer_if_button_pkg::*;
#(
    parameter int          SYNC_STAGES  = 3,
    parameter int          CNT_WIDTH    = 20,
    parameter int unsigned DBNC_CONST   = DEF_DBNC_CONST,
    parameter int          LP_WIDTH     = 24,
    parameter int unsigned LONG_CONST   = DEF_LONG_CONST,
    parameter logic        ACTIVE_LEVEL = ACTIVE_LOW,
    parameter logic        RESET_VALUE  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_input,
    output logic pb_debounced,
    output logic pb_pressed,
    output logic press_p,
    output logic release_p,
    output logic long_p,
    output logic long_held
);

    localparam logic [CNT_WIDTH-1:0] DBNC_LOAD = CNT_WIDTH'(DBNC_CONST);
    localparam logic [LP_WIDTH-1:0]  LONG_MAX  = LP_WIDTH'(LONG_CONST);
    localparam logic                 LONG_EN   = (LONG_CONST != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [LP_WIDTH-1:0]    r_hold;
    logic                   r_deb;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;
    logic                   r_long_held;

    logic w_sync_out;
    logic w_edge;
    logic w_update;
    logic w_going_active;
    logic w_going_idle;
    logic w_pressed;
    logic w_hold_done;

    assign w_sync_out     = r_sync[SYNC_STAGES-1];
    // A change still travelling between the last two stages restarts the window.
    assign w_edge         = w_sync_out ^ r_sync[SYNC_STAGES-2];
    assign w_update       = !w_edge && (r_cnt == '0) && (w_sync_out != r_deb);
    assign w_going_active = w_update && (w_sync_out == ACTIVE_LEVEL);
    assign w_going_idle   = w_update && (w_sync_out != ACTIVE_LEVEL);
    assign w_pressed      = (r_deb == ACTIVE_LEVEL);
    // A release landing in the same cycle wins, so long_held never sets and
    // clears together.
    assign w_hold_done    = LONG_EN && w_pressed && (r_hold == LONG_MAX)
                            && !r_long_held && !w_going_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pb_input};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= DBNC_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb     <= RESET_VALUE;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            if (w_update) begin
                r_deb <= w_sync_out;
            end
            r_press   <= w_going_active;
            r_release <= w_going_idle;
        end
    end

    // Hold counter saturates at LONG_MAX; with LONG_CONST = 0 it never leaves 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (!w_pressed) begin
            r_hold <= '0;
        end else if (r_hold != LONG_MAX) begin
            r_hold <= r_hold + LP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long      <= 1'b0;
            r_long_held <= 1'b0;
        end else begin
            r_long <= w_hold_done;
            if (w_going_idle) begin
                r_long_held <= 1'b0;
            end else if (w_hold_done) begin
                r_long_held <= 1'b1;
            end
        end
    end

    assign pb_debounced = r_deb;
    assign pb_pressed   = w_pressed;
    assign press_p      = r_press;
    assign release_p    = r_release;
    assign long_p       = r_long;
    assign long_held    = r_long_held;

endmodule

// File: rtl/raggedstone_spinn_aer_if_button_bank.sv
// ---------------------------------------------------------------------------
// raggedstone_spinn_aer_if_button_bank
// NUM_CH independent push-button conditioners for the Raggedstone SpiNNaker
// AER interface board, plus a registered any-event flag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pb_input      raw button inputs [NUM_CH], asynchronous to clk
//   pb_debounced  debounced levels, raw polarity
//   pb_pressed    debounced levels, 1 = pressed
//   press_p       per-channel press pulses
//   release_p     per-channel release pulses
//   long_p        per-channel long-press pulses
//   long_held     per-channel long-press level
//   any_event     registered OR of every pulse, one cycle behind them
// ---------------------------------------------------------------------------
module raggedstone_spinn_aer_if_button_bank
    import raggedstone_spinn_aer_if_button_pkg::*;
#(
    parameter int                NUM_CH       = 4,
    parameter int                SYNC_STAGES  = 3,
    parameter int                CNT_WIDTH    = 20,
    parameter int unsigned       DBNC_CONST   = DEF_DBNC_CONST,
    parameter int                LP_WIDTH     = 24,
    parameter int unsigned       LONG_CONST   = DEF_LONG_CONST,
    parameter logic              ACTIVE_LEVEL = ACTIVE_LOW,
    parameter logic [NUM_CH-1:0] RESET_VALUE  = {NUM_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pb_input,
    output logic [NUM_CH-1:0] pb_debounced,
    output logic [NUM_CH-1:0] pb_pressed,
    output logic [NUM_CH-1:0] press_p,
    output logic [NUM_CH-1:0] release_p,
    output logic [NUM_CH-1:0] long_p,
    output logic [NUM_CH-1:0] long_held,
    output logic              any_event
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("SYNC_STAGES outside legal range 2..8");
    end
    if (!value_fits(64'(DBNC_CONST), CNT_WIDTH)) begin : g_bad_dbnc
        $error("DBNC_CONST does not fit in CNT_WIDTH bits");
    end
    if (!value_fits(64'(LONG_CONST), LP_WIDTH)) begin : g_bad_long
        $error("LONG_CONST does not fit in LP_WIDTH bits");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        raggedstone_spinn_aer_if_button_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_WIDTH    (CNT_WIDTH),
            .DBNC_CONST   (DBNC_CONST),
            .LP_WIDTH     (LP_WIDTH),
            .LONG_CONST   (LONG_CONST),
            .ACTIVE_LEVEL (ACTIVE_LEVEL),
            .RESET_VALUE  (RESET_VALUE[i])
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .pb_input     (pb_input[i]),
            .pb_debounced (pb_debounced[i]),
            .pb_pressed   (pb_pressed[i]),
            .press_p      (press_p[i]),
            .release_p    (release_p[i]),
            .long_p       (long_p[i]),
            .long_held    (long_held[i])
        );
    end

    logic w_any;
    logic r_any_event;

    assign w_any = |{press_p, release_p, long_p};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_event <= 1'b0;
        end else begin
            r_any_event <= w_any;
        end
    end

    assign any_event = r_any_event;

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_button_bank.sv
// ---------------------------------------------------------------------------
// tb_raggedstone_spinn_aer_if_button_bank
// Directed bench: NUM_CH=4, SYNC_STAGES=3, DBNC_CONST=4, LONG_CONST=10,
// ACTIVE_LEVEL=0. Expected pulses are given per step by edge index; the bench
// tracks expected debounced level, long_held and any_event from them.
// ---------------------------------------------------------------------------
module tb_raggedstone_spinn_aer_if_button_bank;
    import raggedstone_spinn_aer_if_button_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] pb_input;
    logic [3:0] pb_debounced;
    logic [3:0] pb_pressed;
    logic [3:0] press_p;
    logic [3:0] release_p;
    logic [3:0] long_p;
    logic [3:0] long_held;
    logic       any_event;

    int         n_checks;
    int         n_pass;
    int         n_fail;
    logic [3:0] exp_deb;
    logic [3:0] exp_lh;
    logic       prev_evt;

    raggedstone_spinn_aer_if_button_bank #(
        .NUM_CH       (4),
        .SYNC_STAGES  (3),
        .CNT_WIDTH    (20),
        .DBNC_CONST   (SIM_DBNC_CONST),
        .LP_WIDTH     (24),
        .LONG_CONST   (SIM_LONG_CONST),
        .ACTIVE_LEVEL (ACTIVE_LOW),
        .RESET_VALUE  (4'hF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_input     (pb_input),
        .pb_debounced (pb_debounced),
        .pb_pressed   (pb_pressed),
        .press_p      (press_p),
        .release_p    (release_p),
        .long_p       (long_p),
        .long_held    (long_held),
        .any_event    (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Everything quiet; levels as the model says.
    task automatic check_static(input string tag);
        chk({tag, ".deb"},       pb_debounced, exp_deb);
        chk({tag, ".pressed"},   pb_pressed, ~exp_deb);
        chk({tag, ".press"},     press_p, 4'h0);
        chk({tag, ".release"},   release_p, 4'h0);
        chk({tag, ".long"},      long_p, 4'h0);
        chk({tag, ".long_held"}, long_held, exp_lh);
        chk({tag, ".any"},       {3'b000, any_event}, 4'h0);
    endtask

    // Run n edges; press/release/long vectors are expected at edge indices
    // pe/re/le (1-based, 0 = never), zero elsewhere.
    task automatic watch(input int n, input int pe, input logic [3:0] pv,
                         input int re, input logic [3:0] rv,
                         input int le, input logic [3:0] lv, input string tag);
        logic [3:0] ep, er, el;
        for (int k = 1; k <= n; k++) begin
            step();
            ep = (k == pe) ? pv : 4'h0;
            er = (k == re) ? rv : 4'h0;
            el = (k == le) ? lv : 4'h0;
            exp_deb = (exp_deb & ~ep) | er;
            exp_lh  = (exp_lh | el) & ~er;
            chk($sformatf("%s.press@%0d", tag, k),     press_p, ep);
            chk($sformatf("%s.release@%0d", tag, k),   release_p, er);
            chk($sformatf("%s.long@%0d", tag, k),      long_p, el);
            chk($sformatf("%s.deb@%0d", tag, k),       pb_debounced, exp_deb);
            chk($sformatf("%s.pressed@%0d", tag, k),   pb_pressed, ~exp_deb);
            chk($sformatf("%s.long_held@%0d", tag, k), long_held, exp_lh);
            chk($sformatf("%s.any@%0d", tag, k),       {3'b000, any_event}, {3'b000, prev_evt});
            prev_evt = |{ep, er, el};
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        exp_deb  = 4'hF;
        exp_lh   = 4'h0;
        prev_evt = 1'b0;
        rst      = 1'b1;
        pb_input = 4'hF;

        // Reset with idle-high inputs, then 20 quiet cycles.
        #2;
        check_static("rst0");
        step();
        step();
        check_static("rst_hold");
        rst = 1'b0;
        watch(20, 0, 4'h0, 0, 4'h0, 0, 4'h0, "idle");

        // Clean press on ch0, then release before the long-press threshold.
        pb_input = 4'b1110;
        watch(9, 8, 4'b0001, 0, 4'h0, 0, 4'h0, "ch0_press");
        pb_input = 4'b1111;
        watch(14, 0, 4'h0, 8, 4'b0001, 0, 4'h0, "ch0_release");

        // Bounce 0,1,0 on ch1 at 2-cycle spacing, then hold low.
        pb_input = 4'b1101;
        watch(2, 0, 4'h0, 0, 4'h0, 0, 4'h0, "ch1_b0");
        pb_input = 4'b1111;
        watch(2, 0, 4'h0, 0, 4'h0, 0, 4'h0, "ch1_b1");
        pb_input = 4'b1101;
        watch(9, 8, 4'b0010, 0, 4'h0, 0, 4'h0, "ch1_b2");
        pb_input = 4'b1111;
        watch(10, 0, 4'h0, 8, 4'b0010, 0, 4'h0, "ch1_release");

        // 3-cycle low glitch on ch2 is rejected.
        pb_input = 4'b1011;
        watch(3, 0, 4'h0, 0, 4'h0, 0, 4'h0, "ch2_glitch");
        pb_input = 4'b1111;
        watch(12, 0, 4'h0, 0, 4'h0, 0, 4'h0, "ch2_after");

        // Long press on ch3: long_p 11 edges after press_p, once only.
        pb_input = 4'b0111;
        watch(20, 8, 4'b1000, 0, 4'h0, 19, 4'b1000, "ch3_long");
        watch(6, 0, 4'h0, 0, 4'h0, 0, 4'h0, "ch3_hold");
        pb_input = 4'b1111;
        watch(10, 0, 4'h0, 8, 4'b1000, 0, 4'h0, "ch3_release");

        // Simultaneous ch0+ch1 press, reset 2 cycles before the pulse is due.
        pb_input = 4'b1100;
        watch(6, 0, 4'h0, 0, 4'h0, 0, 4'h0, "simul_pre");
        rst = 1'b1;
        #1;
        exp_deb  = 4'hF;
        exp_lh   = 4'h0;
        prev_evt = 1'b0;
        check_static("rst_mid_a");
        step();
        step();
        step();
        check_static("rst_mid_b");
        rst = 1'b0;

        // Inputs still low: both channels report together after reset release.
        watch(9, 8, 4'b0011, 0, 4'h0, 0, 4'h0, "simul");

        // Asynchronous reset between clock edges while channels are pressed.
        rst = 1'b1;
        #2;
        exp_deb  = 4'hF;
        exp_lh   = 4'h0;
        prev_evt = 1'b0;
        check_static("rst_async");
        pb_input = 4'hF;
        step();
        rst = 1'b0;
        watch(12, 0, 4'h0, 0, 4'h0, 0, 4'h0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/raggedstone_spinn_aer_if_button_bank.md
Name: raggedstone_spinn_aer_if_button_bank

Overview:
- Multi-channel push-button conditioner for the Raggedstone SpiNNaker AER interface board.
- Synchronises, debounces and classifies NUM_CH independent button/switch inputs, using a configurable synchroniser depth and debounce time per bank.
- Emits a debounced level per channel, plus one-cycle press/release/long-press event pulses.
- Outputs feed the user-interface control logic (mode select, reset request, dump triggers).

Parameters:
- NUM_CH, 4: number of independent input channels.
- SYNC_STAGES, 3: synchroniser chain length; legal range 2..8.
- CNT_WIDTH, 20: debounce counter width.
- DBNC_CONST, 20'hfffff: debounce reload value; reduce it for simulation.
- LP_WIDTH, 24: long-press counter width.
- LONG_CONST, 24'hffffff: long-press threshold in clk cycles. 0 disables long-press detection.
- ACTIVE_LEVEL, 1'b0: input level that means "pressed". Applies to all channels.
- RESET_VALUE, {NUM_CH{1'b1}}: per-channel reset value of the synchroniser chain and of pb_debounced.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pb_input  in  NUM_CH  raw button inputs, asynchronous to clk
- pb_debounced  out  NUM_CH  debounced level, in raw polarity
- pb_pressed  out  NUM_CH  debounced level normalised to 1 = pressed
- press_p  out  NUM_CH  one-cycle pulse on debounced transition into ACTIVE_LEVEL
- release_p  out  NUM_CH  one-cycle pulse on debounced transition out of ACTIVE_LEVEL
- long_p  out  NUM_CH  one-cycle pulse when a press has been held LONG_CONST cycles
- long_held  out  NUM_CH  level; high from long_p until the matching release
- any_event  out  1  registered OR of all press_p, release_p and long_p

Behaviour:
- Reset: every register is asynchronously reset, including the synchroniser chain.
  - sync chain[i] = RESET_VALUE[i]; pb_debounced = RESET_VALUE.
  - pb_pressed[i] = (RESET_VALUE[i] == ACTIVE_LEVEL).
  - Debounce counters = 0; hold counters = 0.
  - press_p, release_p, long_p, long_held, any_event = 0.
- No event pulse is generated on reset deassertion.
- Channels are fully independent; each one behaves as described below.
- Synchroniser:
  - s[0] <= pb_input; s[k] <= s[k-1] for k = 1..SYNC_STAGES-1.
  - "Edge" means s[N-1] != s[N-2], where N = SYNC_STAGES.
- Debounce counter:
  - On an edge it reloads DBNC_CONST.
  - Otherwise it decrements when nonzero and holds at 0.
- Debounced update:
  - If there is no edge, cnt == 0 and s[N-1] != pb_debounced, then pb_debounced <= s[N-1].
  - In the same cycle, press_p or release_p is registered high for exactly one cycle.
- Latency: a single clean input change applied before edge 1 appears on pb_debounced, and on its pulse, after clock edge N+DBNC_CONST+1.
- Glitch rejection: any input bounce that reaches s[N-1] restarts the full DBNC_CONST window. An input that returns to its old value before the counter expires produces no event.
- Long press:
  - Hold counter clears whenever pb_pressed = 0.
  - While pb_pressed = 1 and hold != LONG_CONST, it increments each cycle.
  - It saturates at LONG_CONST, with no wrap-around.
  - long_p pulses in the cycle after hold reaches LONG_CONST, once per press.
  - long_held is set with long_p and cleared in the same cycle as release_p.
- Release before threshold: hold is cleared and there is no long_p.
- LONG_CONST = 0: long_p and long_held are never asserted.
- Simultaneous events on different channels are all reported in the same cycle. any_event lags the pulses by one cycle.
- Reset mid-operation (mid-debounce or mid-hold): everything returns to reset values and no pending event is emitted.
- Width rule: DBNC_CONST must fit in CNT_WIDTH and LONG_CONST must fit in LP_WIDTH. Violations are flagged by elaboration-time checks.

Decomposition:
- Shared header raggedstone_spinn_aer_if_button_pkg holds:
  - default DBNC_CONST, LONG_CONST and simulation overrides;
  - the SYNC_STAGES legal limits;
  - the ACTIVE_LOW/ACTIVE_HIGH constants.
- Sub-module raggedstone_spinn_aer_if_button_ch contains one channel: synchroniser, debounce counter, hold counter and pulse logic.
- The top instantiates NUM_CH copies via generate and builds any_event.

Test Plan (NUM_CH=4, SYNC_STAGES=3, DBNC_CONST=4, LONG_CONST=10, ACTIVE_LEVEL=0):
- Reset release with all inputs high:
  - pb_debounced=4'hf, pb_pressed=0 and no pulses for 20 cycles.
- Clean press on ch0 (drive 0 before edge 1, then hold):
  - pb_debounced[0]=0 and press_p[0]=1 after edge 8, for exactly one cycle.
  - any_event=1 after edge 9.
- Bounce on ch1 (0,1,0 at 2-cycle spacing, then hold 0):
  - Exactly one press_p[1], at 8 edges after the last toggle; no release_p.
- 3-cycle glitch low on ch2 from idle high:
  - No press_p or release_p; pb_debounced[2] stays 1.
- Long press on ch3:
  - long_p[3] pulses 11 edges after press_p[3], once only; long_held[3]=1 until release.
  - On release, release_p[3] and long_held[3]=0 in the same cycle.
- Simultaneous press on ch0 and ch1; rst asserted 2 cycles before the expected pulse:
  - No pulses; outputs return to reset values immediately (asynchronously).
